// File: rtl/adc_phase_cal_pkg.sv
// Shared types and defaults for the ADC083000 capture-phase calibration controller.
package adc_phase_cal_pkg;

  localparam int DEF_MAX_STEPS      = 255;
  localparam int DEF_CENTER_OFFSET  = 56;
  localparam int DEF_PSDONE_TIMEOUT = 1023;
  localparam int DEF_MAX_ERRORS     = 4;
  localparam int TMR_W              = 10;

  typedef enum logic [3:0] {
    S_IDLE, S_SRST, S_SREQ, S_SWAIT, S_EVAL,
    S_PS_ISSUE, S_PS_WAIT, S_CTR_ISSUE, S_CTR_WAIT,
    S_DONE, S_FAIL
  } state_t;

endpackage

// File: rtl/adc_phase_cal_if.sv
// MMCM dynamic-phase-shift and clock-sampler handshake bundle.
interface adc_phase_cal_if;
  logic       ps_en;
  logic       ps_incdec;
  logic       ps_done;
  logic       smp_reset;
  logic       smp_req;
  logic       smp_valid;
  logic       smp_dout;
  logic       smp_error;
  logic [7:0] ps_shift_count;

  modport master (
    output ps_en, ps_incdec, smp_reset, smp_req, ps_shift_count,
    input  ps_done, smp_valid, smp_dout, smp_error
  );

  modport slave (
    input  ps_en, ps_incdec, smp_reset, smp_req, ps_shift_count,
    output ps_done, smp_valid, smp_dout, smp_error
  );
endinterface

// File: rtl/adc_phase_cal_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module adc_phase_cal_timer
  import adc_phase_cal_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);
  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/adc_phase_cal.sv
// Phase-sweep calibration: finds the first 1->0 of the sampled ADC clock.
// Define ADC_PHASE_CAL_CENTER_EN to build the post-edge centering shifts.
module adc_phase_cal
  import adc_phase_cal_pkg::*;
#(
  parameter int MAX_STEPS      = DEF_MAX_STEPS,
  parameter int CENTER_OFFSET  = DEF_CENTER_OFFSET,
  parameter int PSDONE_TIMEOUT = DEF_PSDONE_TIMEOUT,
  parameter int MAX_ERRORS     = DEF_MAX_ERRORS
)(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cal_start,
  adc_phase_cal_if.master bus,
  output logic [7:0] edge_step,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail
);
  localparam logic [7:0] MAX_S = 8'(MAX_STEPS);
  localparam logic [7:0] MAX_E = 8'(MAX_ERRORS);
  // Load value chosen so FAIL is entered exactly PSDONE_TIMEOUT cycles after ps_en.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PSDONE_TIMEOUT - 2);

  state_t     state, state_nx;
  logic [7:0] cnt, err_cnt;
  logic       prev_bit, prev_valid, cur_bit;
  logic       tmr_exp, start_ok, edge_hit, err_hit;
`ifdef ADC_PHASE_CAL_CENTER_EN
  localparam logic [7:0] CTR_N = 8'(CENTER_OFFSET);
  logic [7:0] ctr_left;
`endif

  assign start_ok = cal_start & ((state == S_IDLE) | (state == S_DONE) | (state == S_FAIL));
  assign edge_hit = prev_valid & prev_bit & ~cur_bit & (cnt >= 8'd2);
  assign err_hit  = bus.smp_error & ~bus.smp_valid & ((err_cnt + 8'd1) == MAX_E);
  assign bus.ps_incdec      = 1'b1;
  assign bus.ps_shift_count = cnt;

  adc_phase_cal_timer u_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (bus.ps_en),
    .load_val (TMR_LOAD),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_nx      = state;
    bus.ps_en     = 1'b0;
    bus.smp_reset = 1'b0;
    bus.smp_req   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (cal_start) state_nx = S_SRST;
      S_SRST: begin bus.smp_reset = 1'b1; state_nx = S_SREQ; end
      S_SREQ: begin bus.smp_req = 1'b1; state_nx = S_SWAIT; end
      S_SWAIT: begin
        if (bus.smp_valid) state_nx = S_EVAL;
        else if (err_hit)  state_nx = S_PS_ISSUE;
      end
      S_EVAL: begin
        if (edge_hit) begin
`ifdef ADC_PHASE_CAL_CENTER_EN
          state_nx = (CTR_N == 8'd0) ? S_DONE : S_CTR_ISSUE;
`else
          state_nx = S_DONE;
`endif
        end else state_nx = S_PS_ISSUE;
      end
      S_PS_ISSUE: begin
        if (cnt == MAX_S) state_nx = S_FAIL;
        else begin bus.ps_en = 1'b1; state_nx = S_PS_WAIT; end
      end
      S_PS_WAIT: begin
        if (bus.ps_done)  state_nx = S_SRST;
        else if (tmr_exp) state_nx = S_FAIL;
      end
`ifdef ADC_PHASE_CAL_CENTER_EN
      S_CTR_ISSUE: begin bus.ps_en = 1'b1; state_nx = S_CTR_WAIT; end
      S_CTR_WAIT: begin
        if (bus.ps_done)  state_nx = (ctr_left == 8'd1) ? S_DONE : S_CTR_ISSUE;
        else if (tmr_exp) state_nx = S_FAIL;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
    cal_busy = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
    cal_done = (state == S_DONE);
    cal_fail = (state == S_FAIL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      edge_step  <= '0;
      err_cnt    <= '0;
      prev_bit   <= 1'b0;
      prev_valid <= 1'b0;
      cur_bit    <= 1'b0;
`ifdef ADC_PHASE_CAL_CENTER_EN
      ctr_left   <= '0;
`endif
    end else begin
      state <= state_nx;
      if (start_ok) begin
        cnt        <= '0;
        edge_step  <= '0;
        err_cnt    <= '0;
        prev_valid <= 1'b0;
      end
      // valid beats error; a skipped step leaves prev_bit/prev_valid untouched
      if (state == S_SWAIT) begin
        if (bus.smp_valid)      cur_bit <= bus.smp_dout;
        else if (bus.smp_error) err_cnt <= err_hit ? 8'd0 : err_cnt + 8'd1;
      end
      if (state == S_EVAL) begin
        if (edge_hit) begin
          edge_step <= cnt;
`ifdef ADC_PHASE_CAL_CENTER_EN
          ctr_left  <= CTR_N;
`endif
        end else begin
          prev_bit   <= cur_bit;
          prev_valid <= 1'b1;
          err_cnt    <= '0;
        end
      end
      if (bus.ps_done && ((state == S_PS_WAIT) || (state == S_CTR_WAIT)))
        cnt <= cnt + 8'd1;
`ifdef ADC_PHASE_CAL_CENTER_EN
      if (bus.ps_done && (state == S_CTR_WAIT)) ctr_left <= ctr_left - 8'd1;
`endif
    end
  end
endmodule

// File: tb/tb_adc_phase_cal.sv
// Directed bench for adc_phase_cal with a behavioural MMCM + sampler responder.
module tb_adc_phase_cal;
`ifdef ADC_PHASE_CAL_CENTER_EN
  localparam int CTR = 56;
`else
  localparam int CTR = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cal_start = 1'b0;
  logic [7:0] edge_step;
  logic       cal_busy, cal_done, cal_fail;

  adc_phase_cal_if bus();

  adc_phase_cal dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cal_start (cal_start),
    .bus       (bus),
    .edge_step (edge_step),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_fail  (cal_fail)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_bad = 0, cyc = 0, pe_cnt = 0, hold_cyc = 0;
  int edge_at = 40, hold_step = 999, err_step = 999;

  always @(posedge clock) cyc <= cyc + 1;

  // MMCM answers ps_en after 3 cycles (unless withheld); sampler answers
  // smp_req after 2 cycles, or with 4 error pulses on the error step.
  initial begin
    int ps_dly, smp_dly, err_left;
    ps_dly = 0; smp_dly = 0; err_left = 0;
    bus.ps_done = 1'b0; bus.smp_valid = 1'b0; bus.smp_dout = 1'b0; bus.smp_error = 1'b0;
    forever begin
      @(negedge clock);
      bus.ps_done = 1'b0; bus.smp_valid = 1'b0; bus.smp_error = 1'b0;
      if (bus.ps_en) begin
        pe_cnt++;
        if (int'(bus.ps_shift_count) == hold_step) begin ps_dly = 0; hold_cyc = cyc; end
        else ps_dly = 3;
      end else if (ps_dly > 0) begin
        ps_dly--;
        if (ps_dly == 0) bus.ps_done = 1'b1;
      end
      if (bus.smp_req) begin
        smp_dly  = 2;
        err_left = (int'(bus.ps_shift_count) == err_step) ? 4 : 0;
      end else if (err_left > 0) begin
        bus.smp_error = 1'b1;
        err_left--;
        if (err_left == 0) smp_dly = 0;
      end else if (smp_dly > 0) begin
        smp_dly--;
        if (smp_dly == 0) begin
          bus.smp_valid = 1'b1;
          bus.smp_dout  = (int'(bus.ps_shift_count) < edge_at);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic start_cal();
    @(negedge clock); cal_start = 1'b1;
    @(negedge clock); cal_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (cal_done || cal_fail) begin ok = 1'b1; break; end
    end
    chk({tag, "_end"}, 32'(ok), 32'd1);
  endtask

  task automatic run(input string tag, input int e, input int er);
    edge_at = e; err_step = er;
    start_cal();
    wait_end(tag);
  endtask

  initial begin
    int pe0, t_end;
    bit seen;
    repeat (3) @(negedge clock);
    chk("rst_incdec", 32'(bus.ps_incdec), 32'd1);
    chk("rst_ctl", 32'({bus.ps_en, bus.smp_reset, bus.smp_req}), 32'd0);
    chk("rst_stat", 32'({cal_busy, cal_done, cal_fail}), 32'd0);
    chk("rst_cnt", 32'(bus.ps_shift_count), 32'd0);
    chk("rst_edge", 32'(edge_step), 32'd0);
    reset_n = 1'b1;

    // edge at step 40, plus latency and busy-ignore of cal_start
    edge_at = 40; pe0 = pe_cnt;
    start_cal();
    chk("lat_srst", 32'(bus.smp_reset), 32'd1);
    chk("busy", 32'(cal_busy), 32'd1);
    @(negedge clock);
    chk("lat_sreq", 32'(bus.smp_req), 32'd1);
    start_cal();
    wait_end("e40");
    chk("e40_done", 32'({cal_done, cal_fail}), 32'd2);
    chk("e40_edge", 32'(edge_step), 32'd40);
    chk("e40_cnt", 32'(bus.ps_shift_count), 32'((40 + CTR) % 256));
    chk("e40_pe", 32'(pe_cnt - pe0), 32'(40 + CTR));

    // never falls: fail after MAX_STEPS shifts, edge_step cleared by restart
    pe0 = pe_cnt;
    run("hi", 1000, 999);
    chk("hi_fail", 32'({cal_done, cal_fail}), 32'd1);
    chk("hi_edge", 32'(edge_step), 32'd0);
    chk("hi_cnt", 32'(bus.ps_shift_count), 32'd255);
    chk("hi_pe", 32'(pe_cnt - pe0), 32'd255);

    // 1->0 at step 1 is below the minimum step, never qualifies
    run("e1", 1, 999);
    chk("e1_fail", 32'({cal_done, cal_fail}), 32'd1);
    chk("e1_edge", 32'(edge_step), 32'd0);

    // ps_done withheld at step 10
    hold_step = 10; pe0 = pe_cnt;
    run("tmo", 1000, 999);
    t_end = cyc;
    hold_step = 999;
    chk("tmo_fail", 32'({cal_done, cal_fail}), 32'd1);
    chk("tmo_lat", 32'(t_end - hold_cyc), 32'd1023);
    chk("tmo_cnt", 32'(bus.ps_shift_count), 32'd10);
    chk("tmo_pe", 32'(pe_cnt - pe0), 32'd11);

    // four sampler errors at step 20 skip it; edge still found at 21
    pe0 = pe_cnt;
    run("err", 21, 20);
    chk("err_done", 32'({cal_done, cal_fail}), 32'd2);
    chk("err_edge", 32'(edge_step), 32'd21);
    chk("err_cnt", 32'(bus.ps_shift_count), 32'((21 + CTR) % 256));
    chk("err_pe", 32'(pe_cnt - pe0), 32'(21 + CTR));

    // reset during PS_WAIT at step 5, late ps_done must be ignored
    edge_at = 1000; pe0 = pe_cnt; seen = 1'b0;
    start_cal();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (bus.ps_en && bus.ps_shift_count == 8'd5) begin seen = 1'b1; break; end
    end
    chk("rs_reach", 32'(seen), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rs_ctl", 32'({bus.ps_en, bus.smp_reset, bus.smp_req}), 32'd0);
    chk("rs_stat", 32'({cal_busy, cal_done, cal_fail}), 32'd0);
    chk("rs_cnt", 32'(bus.ps_shift_count), 32'd0);
    chk("rs_incdec", 32'(bus.ps_incdec), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("rs_late_cnt", 32'(bus.ps_shift_count), 32'd0);
    chk("rs_late_busy", 32'(cal_busy), 32'd0);
    chk("rs_late_pe", 32'(pe_cnt - pe0), 32'd6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_phase_cal.md
# adc_phase_cal

Phase-sweep calibration controller for the ADC083000 dual-ADC interface. It steps the capture MMCM's dynamic phase shift and, at every step, runs one measurement on the clock-sampler stage that sits directly downstream of it. The measurement reports a stable-high or stable-low level, or an error. The controller finds the first high-to-low transition of the sampled ADC clock, optionally shifts a fixed offset past it to centre the capture eye, and then reports done or fail to the interface control logic.

## Interface
Parameters:
- MAX_STEPS, 255: sweep steps allowed before declaring failure (≤255).
- CENTER_OFFSET, 56: extra increment steps applied after the edge is found.
- PSDONE_TIMEOUT, 1023: cycles to wait for `ps_done` before failing.
- MAX_ERRORS, 4: consecutive sampler errors at one step before that step is skipped.

Ports:
- clock  in  1  the single clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cal_start  in  1  one-cycle pulse that starts calibration.
- ps_en  out  1  one-cycle MMCM phase-shift request.
- ps_incdec  out  1  phase-shift direction; always 1 (increment).
- ps_done  in  1  MMCM phase-shift completion pulse.
- smp_reset  out  1  synchronous active-high reset to the sampler.
- smp_req  out  1  one-cycle sample request to the sampler.
- smp_valid  in  1  sampler result valid (level).
- smp_dout  in  1  sampled level; meaningful only while `smp_valid` is high.
- smp_error  in  1  sampler unstable-window pulse.
- ps_shift_count  out  8  current relative phase step; also feeds the sampler.
- edge_step  out  8  value of `ps_shift_count` at which the edge was detected.
- cal_busy / cal_done / cal_fail  out  1 each  status.

## Operation
States and transitions:
- IDLE: on `cal_start` go to SRST. On entry from DONE or FAIL, clear `ps_shift_count`, `edge_step`, `prev_valid` and the error count.
- SRST: assert `smp_reset` for 1 cycle, then go to SREQ.
- SREQ: assert `smp_req` for 1 cycle, then go to SWAIT.
- SWAIT:
  - `smp_valid` → EVAL.
  - `smp_error` → increment the error count. When the count reaches MAX_ERRORS, clear it, leave `prev_bit`/`prev_valid` unchanged, and go to PS_ISSUE (the step is skipped).
- EVAL:
  - If `prev_valid & prev_bit & ~smp_dout & ps_shift_count ≥ 2`: latch `edge_step`, then go to CTR_ISSUE (or DONE when centering is compiled out).
  - Otherwise: set `prev_bit = smp_dout`, `prev_valid = 1`, clear the error count, and go to PS_ISSUE.
- PS_ISSUE:
  - If `ps_shift_count == MAX_STEPS` → FAIL.
  - Otherwise pulse `ps_en` and go to PS_WAIT.
- PS_WAIT:
  - On `ps_done`: increment `ps_shift_count`, then go to SRST.
  - On timeout → FAIL.
- CTR_ISSUE / CTR_WAIT: behave like PS_ISSUE / PS_WAIT, repeated CENTER_OFFSET times. `ps_shift_count` is incremented modulo 256 (wraps 255→0). After the last `ps_done` go to DONE. No sampling occurs during centering.
- DONE: `cal_done` = 1, held until the next `cal_start`, which returns to IDLE-entry behaviour and starts a new sweep.
- FAIL: `cal_fail` = 1, with the same exit rule as DONE.

General rules:
- `cal_busy` = 1 in every state except IDLE, DONE and FAIL.
- `cal_start` is ignored while busy.
- A `ps_done` arriving outside PS_WAIT/CTR_WAIT is ignored.

## Timing
- Reset values: all outputs are 0, except `ps_incdec` = 1. State is IDLE.
- Asserting `reset_n` mid-sweep aborts immediately. No further `ps_en` is issued.
- Latency:
  - `cal_start` → `smp_reset`: 1 cycle.
  - `smp_reset` → `smp_req`: the next cycle.
  - `smp_valid` → EVAL decision: 1 cycle.
  - EVAL → `ps_en`: 1 cycle.
- `ps_en` is high for exactly one cycle per shift. At most one shift is outstanding at a time.
- The timeout counter is 10 bits. It starts at the `ps_en` cycle and fires when it reaches PSDONE_TIMEOUT.
- `smp_valid` and `smp_error` arriving in the same cycle: `smp_valid` wins.

## Configuration
- `ADC_PHASE_CAL_CENTER_EN` defined: the CTR_ISSUE/CTR_WAIT centering phase is built. After the edge, `ps_shift_count` = `edge_step + CENTER_OFFSET` (mod 256).
- Not defined: EVAL goes straight to DONE on the edge. `ps_shift_count` = `edge_step`. CENTER_OFFSET is unused.

## Structure
- Shared package `adc_phase_cal_pkg`: state encoding constants and the default parameter values.
- One sub-module, `adc_phase_cal_timer`: a 10-bit loadable down-counter with an `expired` flag, used for the `ps_done` timeout.

## Test plan
- Sampler model returns 1 for steps 0–39 and 0 from step 40; centering on; CENTER_OFFSET = 56 → `edge_step` = 40, 96 `ps_en` pulses in total, `ps_shift_count` = 96, `cal_done` = 1.
- Same stimulus with the macro undefined → `cal_done` with `ps_shift_count` = `edge_step` = 40, and exactly 40 `ps_en` pulses.
- Sampler always returns 1 → `cal_fail` after 255 shifts; no edge latched.
- `ps_done` withheld at step 10 → `cal_fail` 1023 cycles after that `ps_en`.
- Four `smp_error` pulses at step 20 (edge at step 21, falling from prior 1) → step 20 skipped, edge still detected at step 21.
- `reset_n` low during PS_WAIT → all outputs at reset values within the same cycle; a late `ps_done` is ignored.
